// File: rtl/args_threshold_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | args_threshold_ctrl_pkg                                              |
// | Shared types, defaults and helpers for the adaptive threshold ctrl.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package args_threshold_ctrl_pkg;

  localparam int c_iw_default      = 10;
  localparam int c_cw_default      = 22;
  localparam int c_th_init_default = 128;

  // ST_IIR is only reachable when the smoothing stage is built in
  typedef enum logic [2:0] {
    ST_ACC  = 3'd0,
    ST_DIV  = 3'd1,
    ST_CALC = 3'd2,
    ST_HOLD = 3'd3,
    ST_IIR  = 3'd4
  } state_t;

  function automatic int sum_width(input int iw, input int cw);
    return iw + cw;
  endfunction

  // Saturate into [0, max_v], then clamp to [lo, hi]; an inverted window yields lo
  function automatic int sat_clamp(input int t, input int max_v,
                                   input int lo, input int hi);
    int v;
    v = (t < 0) ? 0 : ((t > max_v) ? max_v : t);
    if (lo > hi) begin
      v = lo;
    end else if (v < lo) begin
      v = lo;
    end else if (v > hi) begin
      v = hi;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/args_threshold_ctrl_div_seq.sv
// +----------------------------------------------------------------------+
// | args_div_seq                                                         |
// | Start/done restoring divider, one quotient bit per cycle.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module args_div_seq #(
  parameter int SW = 32,
  parameter int CW = 22,
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic          done,
  output logic [IW-1:0] quotient
);

  localparam int c_ctr_w = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [c_ctr_w-1:0] c_last = c_ctr_w'(SW - 1);

  logic [SW-1:0]      r_dvd;
  logic [CW-1:0]      r_div;
  logic [CW-1:0]      r_rem;
  logic [c_ctr_w-1:0] r_cnt;
  logic               r_busy;

  logic [CW:0] w_trial;
  logic [CW:0] w_diff;
  logic        w_ge;

  assign w_trial = {r_rem, r_dvd[SW-1]};
  assign w_diff  = w_trial - {1'b0, r_div};
  assign w_ge    = (w_trial >= {1'b0, r_div});

  // done marks the cycle performing the final step; quotient is valid after it
  assign done = r_busy && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_dvd  <= dividend;
      r_div  <= divisor;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd <= {r_dvd[SW-2:0], w_ge};
      r_rem <= CW'(w_ge ? w_diff : w_trial);
      r_cnt <= r_cnt + c_ctr_w'(1);
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  generate
    if (SW > IW) begin : g_sat
      assign quotient = (|r_dvd[SW-1:IW]) ? {IW{1'b1}} : r_dvd[IW-1:0];
    end else begin : g_nosat
      assign quotient = IW'(r_dvd);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/args_threshold_ctrl.sv
// +----------------------------------------------------------------------+
// | args_threshold_ctrl                                                  |
// | Frame-mean adaptive threshold, applied only at frame start.          |
// | Optional IIR smoothing of the result: define ARGS_TH_IIR_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module args_threshold_ctrl
  import args_threshold_ctrl_pkg::*;
#(
  parameter int IW      = c_iw_default,
  parameter int CW      = c_cw_default,
  parameter int TH_INIT = c_th_init_default
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          in_de,
  input  logic [IW-1:0] in,
  input  logic          cfg_auto,
  input  logic [IW-1:0] cfg_th_man,
  input  logic [IW:0]   cfg_offset,
  input  logic [IW-1:0] cfg_th_min,
  input  logic [IW-1:0] cfg_th_max,
  output logic [IW-1:0] th_out,
  output logic          th_upd,
  output logic          busy,
  output logic          frame_drop
);

  localparam int SW = sum_width(IW, CW);
  localparam logic [IW-1:0] c_th_init = IW'(TH_INIT);
  localparam int c_pix_max = (1 << IW) - 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_pend;
  logic          r_pvld;
  logic [IW-1:0] r_th;
  logic          r_upd;
  logic          r_drop;

  logic                 w_idle;
  logic                 w_start;
  logic                 w_drop_evt;
  logic                 w_div_done;
  logic [IW-1:0]        w_quot;
  logic signed [IW+1:0] w_t;
  logic [IW-1:0]        w_tc;
  logic                 w_pend_wr;
  logic [IW-1:0]        w_pend_val;

  assign w_idle     = (r_state == ST_ACC) || (r_state == ST_HOLD);
  assign w_start    = frame_end && w_idle && (r_cnt != '0);
  // Any frame end while a result is still in flight discards that frame
  assign w_drop_evt = frame_end && !w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (frame_start) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (in_de) begin
      r_sum <= r_sum + SW'(in);
      r_cnt <= r_cnt + CW'(1);
    end
  end

  args_div_seq #(
    .SW (SW),
    .CW (CW),
    .IW (IW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (r_sum),
    .divisor  (r_cnt),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_start) w_state_nxt = ST_DIV;
      end
      ST_HOLD: begin
        if (w_start)                       w_state_nxt = ST_DIV;
        else if (frame_start && cfg_auto)  w_state_nxt = ST_ACC;
      end
      ST_DIV: begin
        if (w_div_done) w_state_nxt = ST_CALC;
      end
`ifdef ARGS_TH_IIR_EN
      ST_CALC: w_state_nxt = ST_IIR;
      ST_IIR:  w_state_nxt = ST_HOLD;
`else
      ST_CALC: w_state_nxt = ST_HOLD;
`endif
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Mean plus signed offset cannot leave the IW+2 signed range
  assign w_t  = $signed({2'b00, w_quot}) + $signed({cfg_offset[IW], cfg_offset});
  assign w_tc = IW'(sat_clamp(int'(w_t), c_pix_max,
                              int'(cfg_th_min), int'(cfg_th_max)));

`ifdef ARGS_TH_IIR_EN
  logic [IW-1:0] r_t;
  logic [IW-1:0] r_th_prev;
  logic [IW+1:0] w_iir_sum;

  assign w_iir_sum  = {2'b00, r_th_prev} + {1'b0, r_th_prev, 1'b0} + {2'b00, r_t};
  assign w_pend_wr  = (r_state == ST_IIR);
  assign w_pend_val = IW'(w_iir_sum >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= '0;
      r_th_prev <= c_th_init;
    end else begin
      if (r_state == ST_CALC) r_t <= w_tc;
      if (frame_start && cfg_auto && r_pvld) r_th_prev <= r_pend;
    end
  end
`else
  assign w_pend_wr  = (r_state == ST_CALC);
  assign w_pend_val = w_tc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_pvld <= 1'b0;
      r_th   <= c_th_init;
      r_upd  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_upd  <= 1'b0;
      r_drop <= w_drop_evt;
      if (frame_start) begin
        if (cfg_auto) begin
          if (r_pvld) begin
            r_th   <= r_pend;
            r_upd  <= 1'b1;
            r_pvld <= 1'b0;
          end
        end else begin
          r_th  <= cfg_th_man;
          r_upd <= (cfg_th_man != r_th);
        end
      end
      // A result landing on a frame_start cycle is kept for the following frame
      if (w_pend_wr) begin
        r_pend <= w_pend_val;
        r_pvld <= 1'b1;
      end
    end
  end

  assign th_out     = r_th;
  assign th_upd     = r_upd;
  assign busy       = (r_state == ST_DIV);
  assign frame_drop = r_drop;

endmodule

`default_nettype wire

// File: doc/args_threshold_ctrl.md
# args_threshold_ctrl

Frame-adaptive threshold controller for the binary stage of the detection pipeline. Accumulates the pixel-intensity sum and active-pixel count of each frame, computes the frame mean with a sequential divider, applies a signed offset and clamp, and drives the stage's threshold input. New thresholds are applied only at frame start, so the threshold never changes mid-frame.

## Interface
- IW, 10, pixel / threshold width
- CW, 22, active-pixel counter width (max 2^CW-1 pixels per frame)
- TH_INIT, 128, threshold value after reset
---
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse before the first pixel of a frame
- frame_end  in  1  one-cycle pulse after the last pixel of a frame
- in_de  in  1  active-pixel qualifier
- in  in  IW  pixel data, same stream the binary stage sees
- cfg_auto  in  1  1 = adaptive mode, 0 = manual
- cfg_th_man  in  IW  manual threshold
- cfg_offset  in  IW+1  signed offset added to the mean
- cfg_th_min  in  IW  lower clamp
- cfg_th_max  in  IW  upper clamp
- th_out  out  IW  threshold to binary stage; reset TH_INIT
- th_upd  out  1  one-cycle pulse when th_out changes source value; reset 0
- busy  out  1  divider running; reset 0
- frame_drop  out  1  one-cycle pulse when a frame's statistics are discarded; reset 0

## Operation
- Sum width SW = IW+CW. Accumulators: sum += in, cnt += 1 on each in_de cycle; both cleared on frame_start (the frame_start cycle itself does not accumulate, even if in_de is high).
- FSM states: ACC, DIV, CALC, HOLD. Reset state ACC.
- ACC: accumulate. On frame_end: if cnt == 0, no update, stay ACC; else latch sum/cnt into divider, go DIV.
- DIV: restoring divider, busy = 1, exactly SW cycles; then CALC.
- CALC (1 cycle): t = mean + cfg_offset in IW+2 signed; saturate to [0, 2^IW-1]; clamp to [cfg_th_min, cfg_th_max]; if cfg_th_min > cfg_th_max, result = cfg_th_min. Store in pending register, set pending flag; go HOLD (equivalent to ACC with pending set).
- Accumulation continues normally in DIV/CALC/HOLD; divider has its own operand copy.
- frame_end while in DIV: that frame's statistics dropped, frame_drop pulses, divider continues.
- On frame_start: cfg_auto = 1 and pending set -> th_out <= pending, clear pending, th_upd = 1. cfg_auto = 0 -> th_out <= cfg_th_man, th_upd = 1 only if value differs. Pending result arriving after a frame_start waits for the next one.
- frame_start and frame_end in the same cycle: frame_end processed with pre-clear accumulators, then cleared.
- Missing frame_end (two frame_starts): accumulators restart, no update.
- Reset mid-operation: all state to reset values, pending cleared, divider aborted.

## Timing
- th_out / th_upd register one cycle after the frame_start cycle.
- frame_end to pending valid: SW+2 cycles (latch, SW divide, CALC).
- Minimum vertical blanking for same-frame application: SW+2 cycles between frame_end and frame_start.
- cfg_* sampled in CALC (offset/clamps) and at frame_start (cfg_auto, cfg_th_man); no synchronisation.

## Configuration
- ARGS_TH_IIR_EN defined: CALC output smoothed as (3·th_prev + t_clamped) >> 2 (floor), th_prev = last applied auto threshold (TH_INIT after reset); adds one CALC cycle (latency SW+3).
- Undefined: clamped value used directly.

## Structure
- Shared package: state encoding, SW derivation, TH_INIT default, saturate/clamp function.
- Sub-module args_div_seq: start/done restoring divider, SW-bit dividend, CW-bit divisor, IW-bit quotient (quotient saturates at 2^IW-1).

## Test plan
- Auto, offset 0, clamps 0/1023, frame of 100 pixels all 200 -> after frame_end + SW+2, next frame_start: th_out = 200, th_upd pulse.
- Offset −300, pixels all 100 -> saturate to 0 then clamp min 16 -> th_out = 16.
- frame_end with no in_de pixels -> no update, th_out stays TH_INIT = 128.
- Second frame_end during DIV -> frame_drop pulse, th_out = first frame's mean only.
- cfg_auto = 0, cfg_th_man = 300 -> th_out = 300 at next frame_start; repeat same value -> no th_upd.
- Assert rst_n low during DIV -> th_out = 128, busy = 0, no later update from aborted frame.
